// File: rtl/cmd_sequencer_if.sv
// Sequencer bus: command FIFO pop side, engine start/done handshake, batch control and status.
// master = host/FIFO/engine side, slave = the sequencer itself.
interface cmd_sequencer_if #(
  parameter int CMD_WORDS = 8,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 7
);
  logic                        op_en;
  logic [CNT_W-1:0]            cmd_size;
  logic                        cmd_valid;
  logic [WORD_W-1:0]           cmd_data;
  logic                        cmd_rd_en;
  logic [CMD_WORDS*WORD_W-1:0] cmd_out;
  logic                        engine_valid;
  logic                        engine_ready;
  logic                        engine_done;
  logic                        engine_reset;
  logic [CNT_W-1:0]            done_count;
  logic                        busy;
  logic                        irq;
  logic                        irq_clr;
  logic                        err;

  modport master (
    output op_en, cmd_size, cmd_valid, cmd_data, engine_ready, engine_done, irq_clr,
    input  cmd_rd_en, cmd_out, engine_valid, engine_reset, done_count, busy, irq, err
  );

  modport slave (
    input  op_en, cmd_size, cmd_valid, cmd_data, engine_ready, engine_done, irq_clr,
    output cmd_rd_en, cmd_out, engine_valid, engine_reset, done_count, busy, irq, err
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Command sequencer: fetches CMD_WORDS-word records into a shadow buffer, issues them to the engine,
// counts completions and raises a sticky irq per batch. Define CMD_TIMEOUT_EN for the RUN watchdog.
module cmd_sequencer #(
  parameter int CMD_WORDS      = 8,
  parameter int WORD_W         = 32,
  parameter int CNT_W          = 7,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           rst,
  cmd_sequencer_if.slave bus
);

  localparam int WC_W = $clog2(CMD_WORDS);

  typedef logic [CMD_WORDS-1:0][WORD_W-1:0] rec_t;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  rec_t             cmd_out_q, cmd_out_d;
  rec_t             shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] fetched_q, fetched_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [CNT_W-1:0] done_inc;
  logic             irq_q, irq_d;
  logic             rd_en;

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_out_d     = cmd_out_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    wcnt_d        = wcnt_q;
    fetched_d     = fetched_q;
    done_count_d  = done_count_q;
    size_d        = size_q;
    irq_d         = irq_q;
    done_inc      = done_count_q + CNT_W'(1);
`ifdef CMD_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_d         = err_q;
`endif

    // Prefetch runs in every active state; a full shadow blocks it until LOAD drains it.
    rd_en = (state_q != IDLE) && (state_q != FINISH) && !shadow_full_q && (fetched_q < size_q);
    if (rd_en && bus.cmd_valid) begin
      shadow_d[wcnt_q] = bus.cmd_data;
      if (wcnt_q == WC_W'(CMD_WORDS - 1)) begin
        wcnt_d        = '0;
        shadow_full_d = 1'b1;
        fetched_d     = fetched_q + CNT_W'(1);
      end else begin
        wcnt_d = wcnt_q + WC_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.op_en) begin
          if (bus.cmd_size != '0) begin
            size_d        = bus.cmd_size;
            fetched_d     = '0;
            done_count_d  = '0;
            wcnt_d        = '0;
            shadow_full_d = 1'b0;
            state_d       = LOAD;
          end else begin
            irq_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      LOAD: begin
        if (shadow_full_q) begin
          cmd_out_d     = shadow_q;
          shadow_full_d = 1'b0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.engine_ready) begin
          state_d = RUN;
`ifdef CMD_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      RUN: begin
        // A completion in the limit cycle takes priority over the watchdog.
        if (bus.engine_done) begin
          done_count_d = done_inc;
          if (done_inc == size_q) begin
            irq_d   = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = LOAD;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      FINISH: begin
        if (bus.irq_clr) begin
          irq_d   = 1'b0;
`ifdef CMD_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_out_q     <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      wcnt_q        <= '0;
      fetched_q     <= '0;
      done_count_q  <= '0;
      size_q        <= '0;
      irq_q         <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_out_q     <= cmd_out_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      wcnt_q        <= wcnt_d;
      fetched_q     <= fetched_d;
      done_count_q  <= done_count_d;
      size_q        <= size_d;
      irq_q         <= irq_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q         <= tmo_d;
      err_q         <= err_d;
`endif
    end
  end

  assign bus.cmd_rd_en    = rd_en;
  assign bus.cmd_out      = cmd_out_q;
  assign bus.engine_valid = (state_q == ISSUE);
  assign bus.engine_reset = (state_q == IDLE) || (state_q == LOAD) || (state_q == FINISH);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done_count   = done_count_q;
  assign bus.irq          = irq_q;

`ifdef CMD_TIMEOUT_EN
  assign bus.err = err_q;
`else
  // Without the watchdog the limit has no effect and err never rises.
  assign bus.err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: FIFO and engine models, record and issue-timing scoreboards.
module tb_cmd_sequencer;
  localparam int CW  = 8;
  localparam int WW  = 32;
  localparam int CNW = 7;
  localparam int TMO = 16;
  localparam int RW  = CW * WW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_sequencer_if #(.CMD_WORDS(CW), .WORD_W(WW), .CNT_W(CNW)) bus ();

  cmd_sequencer #(
    .CMD_WORDS(CW), .WORD_W(WW), .CNT_W(CNW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [WW-1:0] fifo[$];
  logic [RW-1:0] exp_rec[$];
  int            exp_rise[$];

  int   stall_at   = -1;
  int   stall_left = 0;
  int   pop_cnt    = 0;
  int   eng_lat    = 0;
  int   run_left   = 0;
  bit   running    = 0;
  int   done_seen  = 0;
  int   cur_size   = 0;
  int   acc_cnt    = 0;
  logic prev_v     = 1'b0;

  task automatic chk(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic fifo_out();
    if (stall_left > 0) begin
      bus.cmd_valid = 1'b0;
      stall_left--;
    end else begin
      bus.cmd_valid = (fifo.size() > 0);
    end
    bus.cmd_data = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  // One clock: sample handshakes at posedge, update models and drive at negedge.
  task automatic tick();
    logic          x, a;
    logic [RW-1:0] rec, e;
    logic [WW-1:0] w;
    int            er;
    @(posedge clk);
    cyc++;
    x   = bus.cmd_valid && bus.cmd_rd_en;
    a   = bus.engine_valid && bus.engine_ready;
    rec = bus.cmd_out;
    @(negedge clk);
    if (x) begin
      w = fifo.pop_front();
      pop_cnt++;
    end
    bus.engine_done = 1'b0;
    if (running && run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        bus.engine_done = 1'b1;
        running = 0;
        done_seen++;
        if (done_seen < cur_size) exp_rise.push_back(cyc + 2);
      end
    end
    if (a) begin
      acc_cnt++;
      if (exp_rec.size() == 0) chk("rec_unexpected", 1, 0);
      else begin
        e = exp_rec.pop_front();
        chk("cmd_rec", rec, e);
      end
      running  = 1;
      run_left = eng_lat;
    end
    if (stall_at >= 0 && pop_cnt == stall_at) begin
      stall_left = 5;
      stall_at   = -1;
    end
    fifo_out();
    if (bus.engine_valid && !prev_v) begin
      if (exp_rise.size() == 0) chk("rise_unexpected", 1, 0);
      else begin
        er = exp_rise.pop_front();
        chk("vld_rise_cyc", cyc, er);
      end
    end
    prev_v = bus.engine_valid;
  endtask

  task automatic load_rec(input logic [RW-1:0] r);
    for (int k = 0; k < CW; k++) fifo.push_back(r[k*WW +: WW]);
    exp_rec.push_back(r);
    fifo_out();
  endtask

  function automatic logic [RW-1:0] rand_rec();
    logic [RW-1:0] r;
    for (int k = 0; k < CW; k++) r[k*WW +: WW] = $urandom();
    return r;
  endfunction

  task automatic start_batch(input int n, input int lat, input int extra);
    cur_size  = n;
    done_seen = 0;
    eng_lat   = lat;
    pop_cnt   = 0;
    acc_cnt   = 0;
    if (n != 0) exp_rise.push_back(cyc + CW + 2 + extra);
    bus.op_en    = 1'b1;
    bus.cmd_size = CNW'(n);
    tick();
    bus.op_en = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int i = 0;
    while (bus.irq !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    chk("irq_set", bus.irq, 1);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i = 0;
    while (acc_cnt < n && i < budget) begin
      tick();
      i++;
    end
    chk("acc_wait", acc_cnt, n);
  endtask

  task automatic wait_vld(input int budget);
    int i = 0;
    while (bus.engine_valid !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    chk("vld_wait", bus.engine_valid, 1);
  endtask

  task automatic clear_irq();
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_irq"}, bus.irq, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_evld"}, bus.engine_valid, 0);
    chk({tag, "_erst"}, bus.engine_reset, 1);
    chk({tag, "_dcnt"}, bus.done_count, 0);
    chk({tag, "_cout"}, bus.cmd_out, 0);
    chk({tag, "_rden"}, bus.cmd_rd_en, 0);
  endtask

  initial begin
    logic [RW-1:0] r;

    rst              = 1'b1;
    bus.op_en        = 1'b0;
    bus.cmd_size     = '0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_data     = '0;
    bus.engine_ready = 1'b1;
    bus.engine_done  = 1'b0;
    bus.irq_clr      = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("rst0");
    rst = 1'b0;
    tick();

    // single command with known words, FIFO always valid
    for (int k = 0; k < CW; k++) r[k*WW +: WW] = WW'((k + 1) * 32'h11);
    load_rec(r);
    start_batch(1, 4, 0);
    wait_irq(60);
    chk("t1_word0", bus.cmd_out[WW-1:0], 32'h11);
    chk("t1_dcnt", bus.done_count, 1);
    chk("t1_busy", bus.busy, 1);
    clear_irq();
    chk("t1_irq_clr", bus.irq, 0);
    chk("t1_idle", bus.busy, 0);

    // three commands, prefetch overlaps a long engine run
    for (int i = 0; i < 3; i++) load_rec(rand_rec());
    start_batch(3, 20, 0);
    wait_irq(300);
    chk("t2_dcnt", bus.done_count, 3);
    chk("t2_issues", acc_cnt, 3);
    chk("t2_rise_left", exp_rise.size(), 0);
    clear_irq();

    // FIFO stall of 5 cycles after the third word
    load_rec(rand_rec());
    stall_at = 3;
    start_batch(1, 2, 5);
    wait_irq(80);
    chk("t3_dcnt", bus.done_count, 1);
    clear_irq();

    // zero-length batch, then op_en ignored while busy
    for (int k = 0; k < CW; k++) fifo.push_back($urandom());
    fifo_out();
    start_batch(0, 0, 0);
    chk("t4_irq", bus.irq, 1);
    chk("t4_busy", bus.busy, 1);
    bus.op_en    = 1'b1;
    bus.cmd_size = CNW'(1);
    tick();
    bus.op_en = 1'b0;
    repeat (3) tick();
    chk("t4_still_irq", bus.irq, 1);
    chk("t4_no_evld", bus.engine_valid, 0);
    chk("t4_no_pops", pop_cnt, 0);
    clear_irq();
    chk("t4_idle", bus.busy, 0);
    fifo.delete();
    fifo_out();

    // reset in RUN with the shadow half full
    load_rec(rand_rec());
    for (int k = 0; k < CW / 2; k++) fifo.push_back($urandom());
    fifo_out();
    start_batch(2, 0, 0);
    wait_acc(1, 40);
    repeat (8) tick();
    chk("t5_pops", pop_cnt, CW + CW / 2);
    chk("t5_err_quiet", bus.err, 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t5_rst");
    running = 0;
    fifo.delete();
    exp_rec.delete();
    exp_rise.delete();
    fifo_out();
    tick();
    rst = 1'b0;
    tick();
    load_rec(rand_rec());
    start_batch(1, 3, 0);
    wait_irq(60);
    chk("t5_dcnt", bus.done_count, 1);
    chk("t5_fresh_pops", pop_cnt, CW);
    clear_irq();

`ifdef CMD_TIMEOUT_EN
    // watchdog with engine_done withheld
    load_rec(rand_rec());
    load_rec(rand_rec());
    start_batch(2, 0, 0);
    wait_vld(40);
    repeat (TMO) tick();
    chk("t6_err_early", bus.err, 0);
    tick();
    chk("t6_err", bus.err, 1);
    chk("t6_irq", bus.irq, 1);
    chk("t6_dcnt", bus.done_count, 0);
    clear_irq();
    chk("t6_err_clr", bus.err, 0);
    chk("t6_irq_clr", bus.irq, 0);
    chk("t6_idle", bus.busy, 0);
    running = 0;
    fifo.delete();
    exp_rec.delete();
    fifo_out();
`endif

    repeat (2) tick();
    chk("rec_left", exp_rec.size(), 0);
    chk("rise_left", exp_rise.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
Parametrised successor to the command sequencer. Pulls fixed-length command records from the command FIFO and presents each record as a packed word bus to the compute engine. Handshakes start and completion with the engine, counts completed commands and raises a sticky interrupt when the batch is done. Adds a shadow buffer that prefetches command N+1 while the engine runs command N, plus a software interrupt clear and a zero-length-batch path.

Parameters:
CMD_WORDS, 8, number of words per command record (2..16)
WORD_W, 32, FIFO word width
CNT_W, 7, width of batch-size and done counters
TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles (used only with CMD_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
op_en  in  1  batch start pulse; sampled only in IDLE
cmd_size  in  CNT_W  number of commands in batch; sampled on op_en
cmd_valid  in  1  FIFO word available (first-word-fall-through)
cmd_data  in  WORD_W  FIFO word
cmd_rd_en  out  1  FIFO pop; a word transfers on a cycle where cmd_valid && cmd_rd_en
cmd_out  out  CMD_WORDS*WORD_W  active command; word k at bits [k*WORD_W +: WORD_W]
engine_valid  out  1  start request; cmd_out stable while high
engine_ready  in  1  engine accepts the start
engine_done  in  1  single-cycle completion pulse
engine_reset  out  1  engine soft reset
done_count  out  CNT_W  completed commands in current batch
busy  out  1  state not IDLE
irq  out  1  sticky batch-complete interrupt
irq_clr  in  1  clears irq, returns to IDLE
err  out  1  watchdog error flag

Behaviour:
- Reset values: state=IDLE, cmd_out=0, shadow=0, shadow_full=0, word counter=0, fetched=0, done_count=0, irq=0, err=0.
- Reset is honoured mid-operation; all counters clear, nothing is preserved.
- Control states: IDLE, LOAD, ISSUE, RUN, FINISH.
- engine_valid, engine_reset and busy are decoded from the state register.
  - engine_valid is high only in ISSUE.
  - engine_reset is high in IDLE, LOAD and FINISH, and low in ISSUE and RUN.
- IDLE:
  - op_en with cmd_size≠0: latch cmd_size, clear fetched and done_count, go to LOAD.
  - op_en with cmd_size=0: go directly to FINISH.
- Fetch path (independent of control state except IDLE and FINISH):
  - cmd_rd_en = (state∉{IDLE,FINISH}) && !shadow_full && (fetched<cmd_size).
  - Each transferred word is written to shadow word[wcnt], then wcnt increments.
  - On word CMD_WORDS-1: wcnt→0, shadow_full←1, fetched←fetched+1.
  - A low cmd_valid stalls the fetch without loss.
- LOAD: when shadow_full (registered) is high, copy shadow to cmd_out, clear shadow_full, go to ISSUE.
  - A word arriving in the copy cycle is blocked, because cmd_rd_en is gated by shadow_full.
- ISSUE: hold engine_valid. When engine_ready is high, go to RUN.
- RUN:
  - Prefetch of the next record continues in this state.
  - On engine_done, increment done_count.
  - If the new count equals cmd_size, go to FINISH; otherwise go to LOAD.
- engine_done outside RUN is ignored.
- FINISH:
  - irq←1 on entry; irq holds until irq_clr.
  - On irq_clr: irq←0, go to IDLE. done_count holds until the next op_en.
- op_en outside IDLE is ignored.
- Latency: with cmd_valid continuously high, engine_valid rises CMD_WORDS+2 cycles after the op_en cycle.
- Back-to-back issue: if prefetch completes before engine_done, engine_valid rises 2 cycles after the engine_done cycle.
- Counters: done_count and fetched are CNT_W bits. cmd_size ≤ 2^CNT_W−1 guarantees no wrap.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without engine_done: err←1, irq←1, go to FINISH, and the remaining commands are abandoned.
  - irq_clr also clears err.
  - An engine_done arriving in the same cycle as the limit wins: it is counted as normal completion and err stays 0.
- Undefined: err is tied 0, and no counter is synthesised.

Test Plan:
- Single command, CMD_WORDS=8, cmd_size=1, FIFO words 0x11..0x88 with cmd_valid held high, op_en at cycle 0 → engine_valid at cycle 10 and cmd_out[31:0]=0x11. After engine_ready then engine_done: done_count=1, irq=1, busy=1. irq_clr → IDLE, irq=0.
- cmd_size=3, engine takes 20 cycles per command → shadow fills during each RUN, and engine_valid rises exactly 2 cycles after each engine_done. Three issues in total, ending with done_count=3.
- FIFO stall: cmd_valid low for 5 cycles after word 3 → engine_valid is delayed by exactly 5 cycles, and the word order is intact.
- op_en with cmd_size=0 → FINISH and irq=1 next cycle, with no cmd_rd_en pulses. A second op_en while busy has no effect.
- Reset asserted in RUN with the shadow half full → all outputs return to reset values immediately. A following batch with cmd_size=1 fetches a fresh 8-word record.
- CMD_TIMEOUT_EN with TIMEOUT_CYCLES=16 and engine_done withheld → err=1 and irq=1 after 16 RUN cycles. irq_clr clears both.
